// File: rtl/param_accum_xcel.sv
// Memory-reduction accelerator: streams SIZE elements starting at BASE (STRIDE bytes apart)
// and folds them into one registered result (wrapping sum, signed max, signed min or XOR).
module param_accum_xcel #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned SIZE_W = 14,
  parameter int unsigned STRIDE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] base,
  input  logic [SIZE_W-1:0] size,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_val,
  output logic              memreq_val,
  input  logic              memreq_rdy,
  output logic [ADDR_W-1:0] memreq_addr,
  input  logic              memresp_val,
  input  logic [DATA_W-1:0] memresp_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
  typedef enum logic [1:0] {M_SUM, M_MAX, M_MIN, M_XOR} mode_e;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [SIZE_W-1:0] count_q, count_d, count_inc;
  logic [DATA_W-1:0] acc_q, acc_d, acc_upd;
  logic [DATA_W-1:0] result_q, result_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              req_val_q, req_val_d;
  logic              res_val_q, res_val_d;

  // First element seeds max/min so the initial zero accumulator never wins.
  always_comb begin
    acc_upd = acc_q;
    case (mode_q)
      M_SUM:   acc_upd = acc_q + memresp_data;
      M_MAX:   acc_upd = (first_q || ($signed(memresp_data) > $signed(acc_q))) ? memresp_data : acc_q;
      M_MIN:   acc_upd = (first_q || ($signed(memresp_data) < $signed(acc_q))) ? memresp_data : acc_q;
      M_XOR:   acc_upd = acc_q ^ memresp_data;
      default: acc_upd = acc_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    size_d    = size_q;
    count_d   = count_q;
    acc_d     = acc_q;
    result_d  = result_q;
    first_d   = first_q;
    addr_d    = addr_q;
    count_inc = count_q + SIZE_W'(1);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          mode_d  = mode_e'(mode);
          size_d  = size;
          count_d = '0;
          acc_d   = '0;
          first_d = 1'b1;
          addr_d  = base;
          if (size == '0) begin
            state_d  = S_DONE;
            result_d = '0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (memreq_rdy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (memresp_val) begin
          acc_d   = acc_upd;
          count_d = count_inc;
          first_d = 1'b0;
          addr_d  = addr_q + ADDR_W'(STRIDE);
          if (count_inc == size_q) begin
            state_d  = S_DONE;
            result_d = acc_upd;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Status outputs are registered from the next state so they carry no input-to-output path.
    busy_d    = (state_d == S_REQ) || (state_d == S_WAIT);
    req_val_d = (state_d == S_REQ);
    res_val_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= M_SUM;
      size_q    <= '0;
      count_q   <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      first_q   <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      req_val_q <= 1'b0;
      res_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      size_q    <= size_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      first_q   <= first_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      req_val_q <= req_val_d;
      res_val_q <= res_val_d;
    end
  end

  assign busy        = busy_q;
  assign memreq_val  = req_val_q;
  assign result_val  = res_val_q;
  assign result      = result_q;
  assign memreq_addr = addr_q;

endmodule

// File: tb/tb_param_accum_xcel.sv
// Directed bench for param_accum_xcel: the bench plays the memory, keeps a transaction-level
// model of expected outputs, and a negedge compare process checks the DUT every cycle.
module tb_param_accum_xcel;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned SIZE_W = 14;
  localparam int unsigned STRIDE = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              go;
  logic [ADDR_W-1:0] base;
  logic [SIZE_W-1:0] size;
  logic [1:0]        mode;
  logic              busy;
  logic [DATA_W-1:0] result;
  logic              result_val;
  logic              memreq_val;
  logic              memreq_rdy;
  logic [ADDR_W-1:0] memreq_addr;
  logic              memresp_val;
  logic [DATA_W-1:0] memresp_data;

  always #5 clk = ~clk;

  param_accum_xcel #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .SIZE_W(SIZE_W),
    .STRIDE(STRIDE)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .base(base), .size(size), .mode(mode),
    .busy(busy), .result(result), .result_val(result_val),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_addr(memreq_addr),
    .memresp_val(memresp_val), .memresp_data(memresp_data)
  );

  int checks = 0;
  int errors = 0;

  logic              m_en = 1'b0;
  logic              m_busy, m_req, m_rv;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_result;
  logic [DATA_W-1:0] vec [0:15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("memreq_val", 32'(memreq_val), 32'(m_req));
      chk("result_val", 32'(result_val), 32'(m_rv));
      if (m_req) chk("memreq_addr", 32'(memreq_addr), 32'(m_addr));
      if (m_rv)  chk("result", result, m_result);
    end
  end

  // Reduction straight from the mode rules over the element list.
  function automatic logic [DATA_W-1:0] model_reduce(input logic [1:0] md, input int n);
    longint unsigned   s;
    logic signed [31:0] best;
    logic [31:0]       x;
    if (n == 0) return '0;
    s = 0; x = '0; best = $signed(vec[0]);
    for (int i = 0; i < n; i++) begin
      s = s + longint'(vec[i]);
      x = x ^ vec[i];
      if (md == 2'b01 && $signed(vec[i]) > best) best = $signed(vec[i]);
      if (md == 2'b10 && $signed(vec[i]) < best) best = $signed(vec[i]);
    end
    case (md)
      2'b00:   return s[31:0];
      2'b11:   return x;
      default: return best;
    endcase
  endfunction

  task automatic run_op(input logic [ADDR_W-1:0] b, input int n, input logic [1:0] md,
                        input int stall, input bit vary_delay, input bit disturb,
                        input logic [31:0] lit, input string tag);
    logic [31:0] expv;
    int          dly;
    expv = model_reduce(md, n);
    chk({tag, "_model"}, expv, lit);
    base = b; size = SIZE_W'(n); mode = md; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0; base = ~b; size = '1; mode = ~md;
    if (n == 0) begin
      m_busy = 1'b0; m_req = 1'b0; m_rv = 1'b1; m_result = '0;
    end
    for (int i = 0; i < n; i++) begin
      m_busy = 1'b1; m_rv = 1'b0; m_req = 1'b1;
      m_addr = b + ADDR_W'(i * STRIDE);
      for (int s = 0; s < stall; s++) begin
        memreq_rdy = 1'b0;
        if (disturb && s == 0) begin
          go = 1'b1; base = 16'h1234; size = SIZE_W'(1); mode = md ^ 2'b01;
          memresp_val = 1'b1; memresp_data = 32'hDEAD_BEEF;
        end
        @(posedge clk); #1;
        go = 1'b0; memresp_val = 1'b0;
      end
      memreq_rdy = 1'b1;
      @(posedge clk); #1;
      memreq_rdy = 1'b0; m_req = 1'b0;
      dly = vary_delay ? ((i * 3) % 5) : 0;
      for (int d = 0; d < dly; d++) begin
        if (disturb && d == 0) go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
      end
      memresp_val = 1'b1; memresp_data = vec[i];
      @(posedge clk); #1;
      memresp_val = 1'b0;
      if (i == n - 1) begin
        m_busy = 1'b0; m_rv = 1'b1; m_result = expv;
      end
    end
    @(negedge clk);
    chk({tag, "_result"}, result, lit);
    chk({tag, "_rv"}, 32'(result_val), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; base = '0; size = '0; mode = '0;
    memreq_rdy = 1'b0; memresp_val = 1'b0; memresp_data = '0;
    m_busy = 1'b0; m_req = 1'b0; m_rv = 1'b0; m_addr = '0; m_result = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rv", 32'(result_val), 32'd0);
    chk("rst_req", 32'(memreq_val), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_addr", 32'(memreq_addr), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    m_en = 1'b1;
    @(posedge clk); #1;

    vec[0] = 32'd1; vec[1] = 32'd2; vec[2] = 32'd3; vec[3] = 32'd4;
    run_op(16'h0000, 4, 2'b00, 0, 1'b0, 1'b0, 32'd10, "sum4");

    vec[0] = 32'hFFFF_FFFB; vec[1] = 32'd7; vec[2] = 32'hFFFF_FFFF;
    run_op(16'h0200, 3, 2'b01, 0, 1'b0, 1'b0, 32'h0000_0007, "max3");
    run_op(16'h0200, 3, 2'b10, 0, 1'b0, 1'b0, 32'hFFFF_FFFB, "min3");
    run_op(16'h0200, 3, 2'b11, 0, 1'b0, 1'b0, 32'h0000_0003, "xor3");
    run_op(16'h0200, 3, 2'b00, 0, 1'b0, 1'b0, 32'h0000_0001, "sum3");

    vec[0] = 32'h8000_0000;
    run_op(16'h0300, 1, 2'b01, 0, 1'b0, 1'b0, 32'h8000_0000, "max1");

    run_op(16'h0400, 0, 2'b01, 0, 1'b0, 1'b0, 32'h0, "size0_max");
    run_op(16'h0400, 0, 2'b11, 0, 1'b0, 1'b0, 32'h0, "size0_xor");

    vec[0] = 32'hFFFF_FFFF; vec[1] = 32'd1; vec[2] = 32'd0; vec[3] = 32'd0;
    run_op(16'hFFF8, 4, 2'b00, 3, 1'b1, 1'b0, 32'h0, "wrap");

    vec[0] = 32'd3; vec[1] = 32'h8000_0001; vec[2] = 32'd10; vec[3] = 32'd2;
    run_op(16'h0100, 4, 2'b01, 1, 1'b0, 1'b0, 32'd10, "calm");
    run_op(16'h0100, 4, 2'b01, 2, 1'b1, 1'b1, 32'd10, "disturbed");

    vec[0] = 32'h11; vec[1] = 32'h22; vec[2] = 32'h44;
    run_op(16'h0040, 3, 2'b11, 0, 1'b0, 1'b0, 32'h77, "restart");

    // Asynchronous reset while waiting for a response.
    m_en = 1'b0;
    vec[0] = 32'd9;
    base = 16'h0500; size = SIZE_W'(3); mode = 2'b00; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0; memreq_rdy = 1'b1;
    @(posedge clk); #1;
    memreq_rdy = 1'b0;
    chk("wait_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_req", 32'(memreq_val), 32'd0);
    chk("arst_rv", 32'(result_val), 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_addr", 32'(memreq_addr), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    memresp_val = 1'b1; memresp_data = 32'd99;
    @(posedge clk); #1;
    memresp_val = 1'b0;
    @(negedge clk);
    chk("late_busy", 32'(busy), 32'd0);
    chk("late_req", 32'(memreq_val), 32'd0);
    chk("late_rv", 32'(result_val), 32'd0);
    chk("late_result", result, 32'd0);
    @(posedge clk); #1;
    m_busy = 1'b0; m_req = 1'b0; m_rv = 1'b0;
    m_en = 1'b1;

    vec[0] = 32'd5; vec[1] = 32'd6;
    run_op(16'h0600, 2, 2'b00, 0, 1'b0, 1'b0, 32'd11, "post_rst");

    m_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
